rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_if.sv | 30 +++
 rtl/rf_write_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bus between two register-file write requesters, the arbiter and the register file.
// Signal names follow the register-file side naming used by the surrounding core.
interface rf_write_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_reg;
  logic [63:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_reg;
  logic [63:0] req1_data;
  logic        req1_ready;
  logic        stall;
  logic [4:0]  wReg;
  logic [63:0] Data;
  logic        RegWrite;
  logic [1:0]  pend0;
  logic [1:0]  pend1;

  // Requesters and the pipeline control drive this side.
  modport master (
    output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data, stall,
    input  req0_ready, req1_ready, wReg, Data, RegWrite, pend0, pend1
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data, stall,
    output req0_ready, req1_ready, wReg, Data, RegWrite, pend0, pend1
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter. Each requester owns a 2-entry FIFO;
// non-empty heads are arbitrated round robin and the winner is written out as a
// registered single-cycle write pulse. Stall freezes issue but not queueing.
module rf_write_arbiter (
  input logic               clk,
  input logic               reset,
  rf_write_arbiter_if.slave bus
);

  typedef struct packed {
    logic [4:0]  reg_idx;
    logic [63:0] data;
  } entry_t;

  // Queue storage and per-requester pointers (bit r belongs to requester r).
  entry_t      mem_q [2][2];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q [2];
  logic [1:0]  cnt_d [2];

  entry_t      in_entry [2];
  logic [1:0]  in_valid;
  logic [1:0]  ready;
  logic [1:0]  nonempty;
  logic [1:0]  push;
  logic [1:0]  pop;

  logic        grant_valid;
  logic        grant_id;
  logic        last_grant_q, last_grant_d;
  entry_t      head;

  logic [4:0]  wreg_q, wreg_d;
  logic [63:0] data_q, data_d;
  logic        regwrite_q, regwrite_d;

  assign in_valid    = {bus.req1_valid, bus.req0_valid};
  assign in_entry[0] = {bus.req0_reg, bus.req0_data};
  assign in_entry[1] = {bus.req1_reg, bus.req1_data};

  // Occupancy flags; ready looks only at the registered count, never at a same-cycle pop.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      ready[r]    = (cnt_q[r] != 2'd2);
      nonempty[r] = (cnt_q[r] != 2'd0);
    end
  end

  assign push = in_valid & ready;

  // Round-robin arbitration over non-empty heads; a tie goes to the requester that did not win last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!bus.stall) begin
      if (nonempty == 2'b11) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (nonempty[0]) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (nonempty[1]) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign pop  = grant_valid ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign head = mem_q[grant_id][rd_ptr_q[grant_id]];

  // Next state: pointers wrap modulo 2, occupancy moves by push minus pop.
  always_comb begin
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    for (int r = 0; r < 2; r++) begin
      cnt_d[r] = cnt_q[r] + {1'b0, push[r]} - {1'b0, pop[r]};
    end
    regwrite_d   = grant_valid;
    wreg_d       = grant_valid ? head.reg_idx : wreg_q;
    data_d       = grant_valid ? head.data    : data_q;
    last_grant_d = grant_valid ? grant_id     : last_grant_q;
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= 2'b00;
      rd_ptr_q     <= 2'b00;
      cnt_q[0]     <= 2'd0;
      cnt_q[1]     <= 2'd0;
      regwrite_q   <= 1'b0;
      wreg_q       <= 5'd0;
      data_q       <= 64'd0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      regwrite_q   <= regwrite_d;
      wreg_q       <= wreg_d;
      data_q       <= data_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Entry storage written on accepted pushes.
  // NOTE: storage is not reset; emptiness comes from the counts, so stale contents are never read.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) mem_q[r][wr_ptr_q[r]] <= in_entry[r];
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.pend0      = cnt_q[0];
  assign bus.pend1      = cnt_q[1];
  assign bus.wReg       = wreg_q;
  assign bus.Data       = data_q;
  assign bus.RegWrite   = regwrite_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based reference model of the two requester FIFOs and the arbiter.
module tb_rf_write_arbiter;

  logic clk;
  logic rst_n;
  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester, a last-grant index, expected outputs.
  logic [68:0] mq0[$];
  logic [68:0] mq1[$];
  int          m_last = 1;
  logic        m_rw   = 1'b0;
  logic [4:0]  m_wreg = 5'd0;
  logic [63:0] m_data = 64'd0;

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_last = 1;
    m_rw   = 1'b0;
    m_wreg = 5'd0;
    m_data = 64'd0;
  endtask

  task automatic model_step();
    bit          p0, p1;
    int          w;
    logic [68:0] e;
    p0 = bus.req0_valid && (mq0.size() < 2);
    p1 = bus.req1_valid && (mq1.size() < 2);
    w  = -1;
    if (!bus.stall) begin
      if (mq0.size() > 0 && mq1.size() > 0) w = (m_last == 0) ? 1 : 0;
      else if (mq0.size() > 0)              w = 0;
      else if (mq1.size() > 0)              w = 1;
    end
    m_rw = (w >= 0);
    if (w >= 0) begin
      e      = (w == 0) ? mq0.pop_front() : mq1.pop_front();
      m_wreg = e[68:64];
      m_data = e[63:0];
      m_last = w;
    end
    if (p0) mq0.push_back({bus.req0_reg, bus.req0_data});
    if (p1) mq1.push_back({bus.req1_reg, bus.req1_data});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare process on the falling edge, plus a log of observed writes with cycle stamps.
  int          cyc = 0;
  logic [68:0] log_val[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    cyc++;
    check("RegWrite", 64'(bus.RegWrite), 64'(m_rw));
    check("wReg",     64'(bus.wReg),     64'(m_wreg));
    check("Data",     bus.Data,          m_data);
    check("pend0",    64'(bus.pend0),    64'(mq0.size()));
    check("pend1",    64'(bus.pend1),    64'(mq1.size()));
    check("req0_ready", 64'(bus.req0_ready), 64'(mq0.size() < 2));
    check("req1_ready", 64'(bus.req1_ready), 64'(mq1.size() < 2));
    if (bus.RegWrite === 1'b1) begin
      log_val.push_back({bus.wReg, bus.Data});
      log_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_reg   = 5'd0;
    bus.req1_reg   = 5'd0;
    bus.req0_data  = 64'd0;
    bus.req1_data  = 64'd0;
    bus.stall      = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((bus.pend0 != 2'd0 || bus.pend1 != 2'd0 || bus.RegWrite) && guard < 20) begin
      tick();
      guard++;
    end
    check("drain_timeout", 64'(guard < 20), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int s;
    int guard;
    bit accepted;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    // Reset state
    check("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
    check("rst_wReg",     64'(bus.wReg),     64'd0);
    check("rst_Data",     bus.Data,          64'd0);
    check("rst_pend0",    64'(bus.pend0),    64'd0);
    check("rst_ready1",   64'(bus.req1_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Single write: visible two edges after the push, for exactly one cycle
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd5; bus.req0_data = 64'hA5A5;
    tick();
    bus.req0_valid = 1'b0;
    check("single_pend0", 64'(bus.pend0), 64'd1);
    check("single_no_early", 64'(bus.RegWrite), 64'd0);
    tick();
    check("single_RegWrite", 64'(bus.RegWrite), 64'd1);
    check("single_wReg",     64'(bus.wReg),     64'd5);
    check("single_Data",     bus.Data,          64'hA5A5);
    tick();
    check("single_one_cycle", 64'(bus.RegWrite), 64'd0);
    check("single_hold_wReg", 64'(bus.wReg),     64'd5);

    // Tie after reset: requester 0 first, then requester 1
    pulse_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd3; bus.req0_data = 64'd1;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd3; bus.req1_data = 64'd2;
    tick();
    idle_inputs();
    tick();
    check("tie_first_Data", bus.Data, 64'd1);
    check("tie_first_wReg", 64'(bus.wReg), 64'd3);
    tick();
    check("tie_second_rw",   64'(bus.RegWrite), 64'd1);
    check("tie_second_Data", bus.Data, 64'd2);
    tick();

    // Full: requester 1 fills while stalled, third write is held back
    s = log_val.size();
    bus.stall = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd7;
    bus.req1_data = 64'd10; tick();
    bus.req1_data = 64'd11; tick();
    bus.req1_data = 64'd12;
    check("full_ready1_low", 64'(bus.req1_ready), 64'd0);
    check("full_pend1",      64'(bus.pend1),      64'd2);
    tick();
    check("full_pend1_held", 64'(bus.pend1),      64'd2);
    check("full_no_write",   64'(bus.RegWrite),   64'd0);
    bus.stall = 1'b0;
    guard = 0;
    do begin
      accepted = bus.req1_ready;
      tick();
      guard++;
    end while (!accepted && guard < 10);
    check("full_push_timeout", 64'(accepted), 64'd1);
    bus.req1_valid = 1'b0;
    drain();
    check("full_count", 64'(log_val.size() - s), 64'd3);
    if (log_val.size() - s == 3) begin
      check("full_order0", log_val[s][63:0],   64'd10);
      check("full_order1", log_val[s+1][63:0], 64'd11);
      check("full_order2", log_val[s+2][63:0], 64'd12);
    end

    // Fairness: last grant was requester 1, so requester 0 leads and writes alternate without gaps
    s = log_val.size();
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = 1'b1; bus.req0_reg = 5'd1; bus.req0_data = 64'h100 + 64'(i);
      bus.req1_valid = 1'b1; bus.req1_reg = 5'd2; bus.req1_data = 64'h200 + 64'(i);
      tick();
    end
    idle_inputs();
    drain();
    check("fair_count", 64'(log_val.size() - s >= 8), 64'd1);
    if (log_val.size() - s >= 8) begin
      for (int k = 0; k < 8; k++) begin
        check("fair_owner", 64'(log_val[s+k][11:8]), (k % 2 == 0) ? 64'd1 : 64'd2);
        check("fair_no_gap", 64'(log_cyc[s+k] - log_cyc[s]), 64'(k));
      end
    end

    // Reset mid-run: pend0 = 2, one write in flight, reset clears it at once
    bus.stall = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd4; bus.req0_data = 64'h44; tick();
    bus.req0_data = 64'h45; tick();
    bus.req0_valid = 1'b0;
    check("mid_pend0_full", 64'(bus.pend0), 64'd2);
    bus.stall = 1'b0;
    tick();
    check("mid_inflight_rw", 64'(bus.RegWrite), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rw",     64'(bus.RegWrite),   64'd0);
    check("mid_rst_pend0",  64'(bus.pend0),      64'd0);
    check("mid_rst_Data",   bus.Data,            64'd0);
    rst_n = 1'b1;
    s = log_val.size();
    repeat (5) tick();
    check("mid_no_stale", 64'(log_val.size() - s), 64'd0);

    // Stall holds a pending entry; release issues it on the next edge
    bus.stall = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd9; bus.req0_data = 64'h55;
    tick();
    bus.req0_valid = 1'b0;
    check("stall_pend0", 64'(bus.pend0), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_no_write", 64'(bus.RegWrite), 64'd0);
    end
    bus.stall = 1'b0;
    tick();
    check("stall_release_rw",   64'(bus.RegWrite), 64'd1);
    check("stall_release_Data", bus.Data,          64'h55);
    tick();

    // Randomized traffic, including register 0 and repeated destinations
    for (int i = 0; i < 400; i++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req0_reg   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.req1_reg   = ($urandom_range(0, 3) == 0) ? bus.req0_reg : 5'($urandom_range(0, 31));
      bus.req0_data  = {$urandom, $urandom};
      bus.req1_data  = {$urandom, $urandom};
      bus.stall      = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle_inputs();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
